// File: rtl/complex_vxc_add_delay.sv
// Three-stage pipelined complex vector AXPY: result[i] = first[i] +/- constant*second[i].
// Each lane is a packed {real, imag} pair of signed fixed-point values with FRAC fractional bits.
module complex_vxc_add_delay #(
    parameter int NI   = 8,
    parameter int EW   = 64,
    parameter int FRAC = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NI*EW-1:0]   i_first_row,
    input  logic [EW-1:0]      i_constant,
    input  logic [NI*EW-1:0]   i_second_row,
    input  logic               i_op,
    output logic [NI*EW-1:0]   o_result,
    output logic               o_finish
);

    localparam int HW = EW / 2;

    logic [NI*EW-1:0] r_first1;
    logic [NI*EW-1:0] r_second1;
    logic [EW-1:0]    r_const1;
    logic             r_op1;

    logic [NI*EW-1:0] r_first2;
    logic [NI*EW-1:0] r_prod2;
    logic             r_op2;

    logic [NI*EW-1:0] r_result;
    logic [1:0]       r_fill_cnt;

    logic [NI*EW-1:0] w_prod;
    logic [NI*EW-1:0] w_sum;

    // Operands are sign-extended to the full product width so the sums of
    // products cannot lose their upper bits before the fractional shift.
    function automatic logic [EW-1:0] cmul(input logic [EW-1:0] x, input logic [EW-1:0] k);
        logic signed [EW-1:0] a, b, c, d, pr, pi;
        a  = {{HW{x[EW-1]}}, x[EW-1:HW]};
        b  = {{HW{x[HW-1]}}, x[HW-1:0]};
        c  = {{HW{k[EW-1]}}, k[EW-1:HW]};
        d  = {{HW{k[HW-1]}}, k[HW-1:0]};
        pr = a * c - b * d;
        pi = a * d + b * c;
        return {HW'(pr >>> FRAC), HW'(pi >>> FRAC)};
    endfunction

    function automatic logic [EW-1:0] addsub(input logic [EW-1:0] f, input logic [EW-1:0] p,
                                             input logic op);
        logic [HW-1:0] re, im;
        if (op) begin
            re = f[EW-1:HW] - p[EW-1:HW];
            im = f[HW-1:0]  - p[HW-1:0];
        end else begin
            re = f[EW-1:HW] + p[EW-1:HW];
            im = f[HW-1:0]  + p[HW-1:0];
        end
        return {re, im};
    endfunction

    always_comb begin
        w_prod = '0;
        w_sum  = '0;
        for (int i = 0; i < NI; i++) begin
            w_prod[i*EW +: EW] = cmul(r_second1[i*EW +: EW], r_const1);
            w_sum[i*EW +: EW]  = addsub(r_first2[i*EW +: EW], r_prod2[i*EW +: EW], r_op2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_first1   <= '0;
            r_second1  <= '0;
            r_const1   <= '0;
            r_op1      <= 1'b0;
            r_first2   <= '0;
            r_prod2    <= '0;
            r_op2      <= 1'b0;
            r_result   <= '0;
            r_fill_cnt <= 2'd0;
        end else begin
            r_first1  <= i_first_row;
            r_second1 <= i_second_row;
            r_const1  <= i_constant;
            r_op1     <= i_op;
            r_first2  <= r_first1;
            r_prod2   <= w_prod;
            r_op2     <= r_op1;
            r_result  <= w_sum;
            // Saturates at 3: one count per stage that now holds post-reset data
            if (r_fill_cnt != 2'd3) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end
        end
    end

    assign o_result = r_result;
    assign o_finish = (r_fill_cnt == 2'd3);

endmodule

// File: tb/tb_complex_vxc_add_delay.sv
// Bench for complex_vxc_add_delay: fixed-vector table, hand-written reset/latency sequences
// and randomized traffic checked against a queue-based arithmetic reference model.
module tb_complex_vxc_add_delay;

    localparam int NI = 8;
    localparam int EW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [NI*EW-1:0] first_row;
    logic [EW-1:0]   cst;
    logic [NI*EW-1:0] second_row;
    logic            op;
    logic [NI*EW-1:0] result;
    logic            finish;

    int checks   = 0;
    int failures = 0;

    logic [NI*EW-1:0] exp_q[$];
    int               since_rst = 0;

    complex_vxc_add_delay #(.NI(NI), .EW(EW), .FRAC(16)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_first_row  (first_row),
        .i_constant   (cst),
        .i_second_row (second_row),
        .i_op         (op),
        .o_result     (result),
        .o_finish     (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] first;
        logic [63:0] k;
        logic [63:0] second;
        logic        op;
        logic [63:0] expv;
    } vec_t;

    vec_t tbl[6];

    // Plain integer arithmetic: full products, floor-shift by 16, 32-bit wrap.
    function automatic logic [63:0] ref_lane(input logic [63:0] f, input logic [63:0] k,
                                             input logic [63:0] s, input logic o);
        int a, b, c, d, fr, fi, pr_t, pi_t;
        longint pr, pi;
        a  = s[63:32];
        b  = s[31:0];
        c  = k[63:32];
        d  = k[31:0];
        fr = f[63:32];
        fi = f[31:0];
        pr = longint'(a) * longint'(c) - longint'(b) * longint'(d);
        pi = longint'(a) * longint'(d) + longint'(b) * longint'(c);
        pr_t = int'(pr >>> 16);
        pi_t = int'(pi >>> 16);
        if (o) begin
            fr = fr - pr_t;
            fi = fi - pi_t;
        end else begin
            fr = fr + pr_t;
            fi = fi + pi_t;
        end
        return {fr, fi};
    endfunction

    function automatic logic [NI*EW-1:0] ref_vec(input logic [NI*EW-1:0] f, input logic [63:0] k,
                                                 input logic [NI*EW-1:0] s, input logic o);
        logic [NI*EW-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) r[i*EW +: EW] = ref_lane(f[i*EW +: EW], k, s[i*EW +: EW], o);
        return r;
    endfunction

    function automatic logic [NI*EW-1:0] rand_vec();
        logic [NI*EW-1:0] r;
        for (int i = 0; i < NI*EW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [NI*EW-1:0] act, input logic [NI*EW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Drive one sample after the falling edge, advance the model, check after the rising edge.
    task automatic cyc(input logic [NI*EW-1:0] f, input logic [63:0] k,
                       input logic [NI*EW-1:0] s, input logic o, input logic r);
        logic [NI*EW-1:0] e;
        logic             ef;
        @(negedge clk);
        first_row  = f;
        cst        = k;
        second_row = s;
        op         = o;
        reset      = r;
        if (r) begin
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            e = '0;
            since_rst = 0;
        end else begin
            exp_q.push_back(ref_vec(f, k, s, o));
            e = exp_q.pop_front();
            if (since_rst < 3) since_rst++;
        end
        ef = (since_rst >= 3);
        @(posedge clk);
        #1;
        chk("model_result", result, e);
        chk("model_finish", {{(NI*EW-1){1'b0}}, finish}, {{(NI*EW-1){1'b0}}, ef});
    endtask

    initial begin
        logic [NI*EW-1:0] rf, rs;
        logic [63:0]      rk;

        tbl[0] = '{"add_2x", 64'h00030000_00000000, 64'h00020000_00000000, 64'h00010000_00010000, 1'b0, 64'h00050000_00020000};
        tbl[1] = '{"sub_2x", 64'h00030000_00000000, 64'h00020000_00000000, 64'h00010000_00010000, 1'b1, 64'h00010000_FFFE0000};
        tbl[2] = '{"j_times_j", 64'h0, 64'h00000000_00010000, 64'h00000000_00010000, 1'b0, 64'hFFFF0000_00000000};
        tbl[3] = '{"floor_trunc", 64'h0, 64'h00000001_00000000, 64'hFFFFFFFF_00000000, 1'b0, 64'hFFFFFFFF_00000000};
        tbl[4] = '{"wrap_pos", 64'h7FFFFFFF_00000000, 64'h00010000_00000000, 64'h00000001_00000000, 1'b0, 64'h80000000_00000000};
        tbl[5] = '{"wrap_sub_imag", 64'h00000000_80000000, 64'h00010000_00000000, 64'h00000000_00000001, 1'b1, 64'h00000000_7FFFFFFF};

        first_row = '0; cst = '0; second_row = '0; op = 1'b0; reset = 1'b1;

        // Reset held two cycles, then finish must rise on exactly the 3rd edge.
        cyc('0, '0, '0, 1'b0, 1'b1);
        cyc('0, '0, '0, 1'b0, 1'b1);
        chk("reset_result", result, '0);
        chk("reset_finish", {{(NI*EW-1){1'b0}}, finish}, '0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        chk("fill_edge1", {{(NI*EW-1){1'b0}}, finish}, '0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        chk("fill_edge2", {{(NI*EW-1){1'b0}}, finish}, '0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        chk("fill_edge3", {{(NI*EW-1){1'b0}}, finish}, {{(NI*EW-1){1'b0}}, 1'b1});

        // Table vectors: each held for three edges, then every lane compared.
        for (int t = 0; t < 6; t++) begin
            for (int h = 0; h < 3; h++)
                cyc({NI{tbl[t].first}}, tbl[t].k, {NI{tbl[t].second}}, tbl[t].op, 1'b0);
            chk(tbl[t].name, result, {NI{tbl[t].expv}});
        end

        // Back-to-back random vectors with op toggling every cycle.
        for (int i = 0; i < 24; i++) begin
            rf = rand_vec();
            rs = rand_vec();
            rk = {$urandom, $urandom};
            cyc(rf, rk, rs, i[0], 1'b0);
        end

        // One-cycle reset mid-stream.
        cyc(rand_vec(), {$urandom, $urandom}, rand_vec(), 1'b1, 1'b1);
        chk("midrst_result", result, '0);
        chk("midrst_finish", {{(NI*EW-1){1'b0}}, finish}, '0);
        cyc({NI{tbl[0].first}}, tbl[0].k, {NI{tbl[0].second}}, 1'b0, 1'b0);
        chk("midrst_e1_result", result, '0);
        cyc(rand_vec(), {$urandom, $urandom}, rand_vec(), 1'b0, 1'b0);
        chk("midrst_e2_finish", {{(NI*EW-1){1'b0}}, finish}, '0);
        cyc(rand_vec(), {$urandom, $urandom}, rand_vec(), 1'b1, 1'b0);
        chk("midrst_e3_result", result, {NI{tbl[0].expv}});
        chk("midrst_e3_finish", {{(NI*EW-1){1'b0}}, finish}, {{(NI*EW-1){1'b0}}, 1'b1});

        for (int i = 0; i < 16; i++)
            cyc(rand_vec(), {$urandom, $urandom}, rand_vec(), 1'($urandom_range(0, 1)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
